// File: rtl/fib_pkg.sv
// Shared Fibonacci definitions: checker state encoding and default widths,
// common to the generator and the checker.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 4;
  localparam int unsigned FIB_CNT_W = 8;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SEED  = 2'd1,
    TRACK = 2'd2
  } fib_state_e;

endpackage : fib_pkg

// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker: locks onto a 0,1 seed, then predicts every
// following sample as (prev+curr) mod 2^WIDTH and flags matches/mismatches.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     in_data carries a sample this cycle
//   in_data      sample from the Fibonacci generator
//   resync       drop tracking and hunt for a new seed (no pulse, counters kept)
//   locked       registered, high while in TRACK
//   match        one-cycle pulse: last sample equalled the prediction
//   mismatch     one-cycle pulse: last sample differed while locked
//   expected     prediction for the next sample (valid when locked)
//   match_count  saturating match counter
//   error_count  saturating mismatch counter
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             resync,
  output logic             locked,
  output logic             match,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] error_count
);

  fib_state_e       state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [WIDTH-1:0] curr, curr_nxt;
  logic             match_nxt, mismatch_nxt;
  logic [CNT_W-1:0] match_count_nxt, error_count_nxt;
  logic [WIDTH-1:0] expected_nxt;

  // Next-state, datapath and pulse decode
  always_comb begin
    state_nxt       = state;
    prev_nxt        = prev;
    curr_nxt        = curr;
    match_nxt       = 1'b0;
    mismatch_nxt    = 1'b0;
    match_count_nxt = match_count;
    error_count_nxt = error_count;

    if (resync) begin
      state_nxt = HUNT;
    end else if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_data == '0) state_nxt = SEED;
        end
        SEED: begin
          if (in_data == WIDTH'(1)) begin
            prev_nxt  = '0;
            curr_nxt  = WIDTH'(1);
            state_nxt = TRACK;
          end else if (in_data != '0) begin
            state_nxt = HUNT;
          end
        end
        TRACK: begin
          if (in_data == expected) begin
            match_nxt = 1'b1;
            prev_nxt  = curr;
            curr_nxt  = in_data;
            if (match_count != '1) match_count_nxt = match_count + CNT_W'(1);
          end else begin
            mismatch_nxt = 1'b1;
            if (error_count != '1) error_count_nxt = error_count + CNT_W'(1);
            // A wrong 0 can itself be the start of a fresh seed
            state_nxt = (in_data == '0) ? SEED : HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // Modular adder: carry out is intentionally dropped
    expected_nxt = prev_nxt + curr_nxt;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      prev        <= '0;
      curr        <= '0;
      expected    <= '0;
      locked      <= 1'b0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      match_count <= '0;
      error_count <= '0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      curr        <= curr_nxt;
      expected    <= expected_nxt;
      locked      <= (state_nxt == TRACK);
      match       <= match_nxt;
      mismatch    <= mismatch_nxt;
      match_count <= match_count_nxt;
      error_count <= error_count_nxt;
    end
  end

endmodule : fibonacci_checker
